am_atten_mix: RTL and testbench
===============================

AM_ATTEN_MIX -- requirements
Module: am_atten_mix

Interface
REQ-001 Parameter ATT_MAX, default 511, saturation ceiling of total attenuation (9-bit, 0.1875 dB/LSB).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sample_clk_en  input  1  one-cycle strobe marking start of a sample frame (op_num == 0 slot).
REQ-005 op_num  input  `OP_NUM_WIDTH  operator slot of current input, 0..17.
REQ-006 in_valid  input  1  env_in, tl, ksl_att, am_en, op_num valid this cycle.
REQ-007 am_val  input  `AM_VAL_WIDTH  tremolo LFO depth value, 0..26.
REQ-008 am_en  input  1  operator AM enable bit (register 0x20-0x35 bit 7).
REQ-009 env_in  input  9  envelope generator attenuation.
REQ-010 tl  input  6  total level, 0.75 dB/LSB.
REQ-011 ksl_att  input  8  precomputed key-scale-level attenuation, 0.1875 dB/LSB.
REQ-012 out_valid  output  1  att_out/op_num_out valid.
REQ-013 att_out  output  9  final saturated attenuation to operator log-sin stage.
REQ-014 op_num_out  output  `OP_NUM_WIDTH  operator slot of att_out.
REQ-015 sat_flag  output  1  sticky: any saturation since reset or last frame start.

Function
REQ-016 Stage 1 SHALL register inputs when in_valid=1; am term = am_en ? am_src : 0, where am_src is per REQ-027.
REQ-017 Stage 2 SHALL compute sum = env_in + (tl << 2) + ksl_att + am term in 11-bit unsigned arithmetic, with no intermediate truncation.
REQ-018 Stage 3 SHALL output att_out = (sum > ATT_MAX) ? ATT_MAX : sum[8:0].
REQ-019 Latency SHALL be exactly 3 cycles from in_valid to out_valid; out_valid is in_valid delayed 3 cycles.
REQ-020 op_num_out SHALL travel with its data through all stages unchanged.
REQ-021 When in_valid=0, pipeline data registers SHALL hold their values and the valid bit SHALL propagate 0; att_out is unchanged while out_valid=0.
REQ-022 Back-to-back in_valid SHALL be accepted every cycle (throughput 1/cycle, no stall).
REQ-023 sat_flag SHALL set in the cycle att_out saturates; it SHALL clear on sample_clk_en unless saturation occurs in that same cycle (set wins).
REQ-024 Boundary: sum == ATT_MAX passes unclamped; sum == ATT_MAX+1 clamps and sets sat_flag.
REQ-025 Worst case 511+252+255+26 = 1044 SHALL fit in 11 bits without wrap.

Reset
REQ-026 On rst: all valid bits 0, att_out 0, op_num_out 0, sat_flag 0, held AM value 0; rst mid-stream discards in-flight data and the first out_valid follows the first post-reset in_valid by 3 cycles.

Configuration
REQ-027 Macro AM_FRAME_HOLD_EN: defined -> am_val SHALL be captured into a hold register on sample_clk_en and am_src = hold register, so all 18 operators of a frame see one value; undefined -> am_src = am_val sampled in stage 1 directly, no hold register.

Verification
REQ-028 env_in=100, tl=10, ksl_att=20, am_en=1, am_val=26, in_valid pulse, op_num=5 -> 3 cycles later out_valid=1, att_out=186, op_num_out=5, sat_flag=0.
REQ-029 Same stimulus with am_en=0 -> att_out=160.
REQ-030 env_in=511, tl=63, ksl_att=255, am_val=26, am_en=1 -> att_out=511, sat_flag=1; next sample_clk_en with no saturation -> sat_flag=0.
REQ-031 env_in=487, tl=0, ksl_att=0, am_en=1, am_val 24 vs 25 -> att_out 511 with sat_flag=0, then 511 with sat_flag=1.
REQ-032 With AM_FRAME_HOLD_EN: am_val=10 at sample_clk_en, changed to 20 before op 17 input -> op 17 att_out uses 10; without macro uses 20.
REQ-033 18 consecutive in_valid cycles then rst asserted on cycle 2 of drain -> no out_valid until new input; all outputs 0.

Source files
------------

// File: rtl/am_atten_mix.sv
// am_atten_mix: three-stage operator attenuation mixer (env + TL + KSL + AM).
// Optional macro AM_FRAME_HOLD_EN freezes am_val once per sample frame.

`ifndef OP_NUM_WIDTH
`define OP_NUM_WIDTH 5
`endif

`ifndef AM_VAL_WIDTH
`define AM_VAL_WIDTH 5
`endif

module am_atten_mix #(
    parameter int unsigned ATT_MAX = 511
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_clk_en,
    input  logic [`OP_NUM_WIDTH-1:0] op_num,
    input  logic                     in_valid,
    input  logic [`AM_VAL_WIDTH-1:0] am_val,
    input  logic                     am_en,
    input  logic [8:0]               env_in,
    input  logic [5:0]               tl,
    input  logic [7:0]               ksl_att,
    output logic                     out_valid,
    output logic [8:0]               att_out,
    output logic [`OP_NUM_WIDTH-1:0] op_num_out,
    output logic                     sat_flag
);

    localparam int OPW = `OP_NUM_WIDTH;
    localparam int AMW = `AM_VAL_WIDTH;

    localparam logic [10:0] ATT_MAX_W = 11'(ATT_MAX);
    localparam logic [8:0]  ATT_MAX_9 = 9'(ATT_MAX);

    // AM depth source seen by stage 1
    logic [AMW-1:0] am_src;

`ifdef AM_FRAME_HOLD_EN
    logic [AMW-1:0] am_hold_q;
    logic [AMW-1:0] am_hold_d;

    // Capture the LFO depth at each frame start
    always_comb begin
        am_hold_d = am_hold_q;
        if (sample_clk_en) begin
            am_hold_d = am_val;
        end
    end

    // Frame-hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            am_hold_q <= '0;
        end else begin
            am_hold_q <= am_hold_d;
        end
    end

    // Slot 0 arrives with the strobe, so it takes the fresh value
    assign am_src = sample_clk_en ? am_val : am_hold_q;
`else
    assign am_src = am_val;
`endif

    // Stage 1 registers
    logic           s1_vld_q, s1_vld_d;
    logic [8:0]     s1_env_q, s1_env_d;
    logic [5:0]     s1_tl_q,  s1_tl_d;
    logic [7:0]     s1_ksl_q, s1_ksl_d;
    logic [AMW-1:0] s1_am_q,  s1_am_d;
    logic [OPW-1:0] s1_op_q,  s1_op_d;

    // Stage 2 registers
    logic           s2_vld_q, s2_vld_d;
    logic [10:0]    s2_sum_q, s2_sum_d;
    logic [OPW-1:0] s2_op_q,  s2_op_d;

    // Stage 3 (output) registers
    logic           s3_vld_q, s3_vld_d;
    logic [8:0]     s3_att_q, s3_att_d;
    logic [OPW-1:0] s3_op_q,  s3_op_d;
    logic           sat_q,    sat_d;

    logic           sat_now;

    // Stage 1: capture operands, gate AM by the operator enable
    always_comb begin
        s1_vld_d = in_valid;
        s1_env_d = s1_env_q;
        s1_tl_d  = s1_tl_q;
        s1_ksl_d = s1_ksl_q;
        s1_am_d  = s1_am_q;
        s1_op_d  = s1_op_q;
        if (in_valid) begin
            s1_env_d = env_in;
            s1_tl_d  = tl;
            s1_ksl_d = ksl_att;
            s1_am_d  = am_en ? am_src : '0;
            s1_op_d  = op_num;
        end
    end

    // Stage 2: full-width sum, wide enough for the worst case of 1044
    always_comb begin
        s2_vld_d = s1_vld_q;
        s2_sum_d = s2_sum_q;
        s2_op_d  = s2_op_q;
        if (s1_vld_q) begin
            s2_sum_d = 11'(s1_env_q)
                     + {3'b000, s1_tl_q, 2'b00}
                     + 11'(s1_ksl_q)
                     + 11'(s1_am_q);
            s2_op_d  = s1_op_q;
        end
    end

    assign sat_now = s2_vld_q && (s2_sum_q > ATT_MAX_W);

    // Stage 3: clamp to ceiling; sticky flag where a new saturation beats the frame clear
    always_comb begin
        s3_vld_d = s2_vld_q;
        s3_att_d = s3_att_q;
        s3_op_d  = s3_op_q;
        sat_d    = sat_q & ~sample_clk_en;
        if (s2_vld_q) begin
            s3_att_d = sat_now ? ATT_MAX_9 : s2_sum_q[8:0];
            s3_op_d  = s2_op_q;
        end
        if (sat_now) begin
            sat_d = 1'b1;
        end
    end

    // Pipeline state; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_env_q <= '0;
            s1_tl_q  <= '0;
            s1_ksl_q <= '0;
            s1_am_q  <= '0;
            s1_op_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_sum_q <= '0;
            s2_op_q  <= '0;
            s3_vld_q <= 1'b0;
            s3_att_q <= '0;
            s3_op_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_env_q <= s1_env_d;
            s1_tl_q  <= s1_tl_d;
            s1_ksl_q <= s1_ksl_d;
            s1_am_q  <= s1_am_d;
            s1_op_q  <= s1_op_d;
            s2_vld_q <= s2_vld_d;
            s2_sum_q <= s2_sum_d;
            s2_op_q  <= s2_op_d;
            s3_vld_q <= s3_vld_d;
            s3_att_q <= s3_att_d;
            s3_op_q  <= s3_op_d;
            sat_q    <= sat_d;
        end
    end

    assign out_valid  = s3_vld_q;
    assign att_out    = s3_att_q;
    assign op_num_out = s3_op_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_am_atten_mix.sv
// tb_am_atten_mix: directed vector table plus hand sequences for am_atten_mix.
// Expected values are hand-computed from env + 4*tl + ksl + am, clamped at 511.

`ifndef OP_NUM_WIDTH
`define OP_NUM_WIDTH 5
`endif

`ifndef AM_VAL_WIDTH
`define AM_VAL_WIDTH 5
`endif

module tb_am_atten_mix;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     sample_clk_en = 1'b0;
    logic [`OP_NUM_WIDTH-1:0] op_num = '0;
    logic                     in_valid = 1'b0;
    logic [`AM_VAL_WIDTH-1:0] am_val = '0;
    logic                     am_en = 1'b0;
    logic [8:0]               env_in = '0;
    logic [5:0]               tl = '0;
    logic [7:0]               ksl_att = '0;
    logic                     out_valid;
    logic [8:0]               att_out;
    logic [`OP_NUM_WIDTH-1:0] op_num_out;
    logic                     sat_flag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8:0]               env;
        logic [5:0]               tl;
        logic [7:0]               ksl;
        logic                     am_en;
        logic [`AM_VAL_WIDTH-1:0] am;
        logic [`OP_NUM_WIDTH-1:0] op;
        logic [8:0]               att;
        logic                     sat;
    } vec_t;

    vec_t vecs[15];

    am_atten_mix #(.ATT_MAX(511)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_clk_en (sample_clk_en),
        .op_num        (op_num),
        .in_valid      (in_valid),
        .am_val        (am_val),
        .am_en         (am_en),
        .env_in        (env_in),
        .tl            (tl),
        .ksl_att       (ksl_att),
        .out_valid     (out_valid),
        .att_out       (att_out),
        .op_num_out    (op_num_out),
        .sat_flag      (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one input for one cycle, then count edges until out_valid (bounded)
    task automatic send(input vec_t v, input logic sce, output int lat);
        @(negedge clk);
        env_in        = v.env;
        tl            = v.tl;
        ksl_att       = v.ksl;
        am_en         = v.am_en;
        am_val        = v.am;
        op_num        = v.op;
        in_valid      = 1'b1;
        sample_clk_en = sce;
        tick();
        in_valid      = 1'b0;
        sample_clk_en = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic pulse_sce();
        @(negedge clk);
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   lat;

        vecs[0]  = '{9'd100, 6'd10, 8'd20,  1'b1, 5'd26, 5'd5,  9'd186, 1'b0};
        vecs[1]  = '{9'd100, 6'd10, 8'd20,  1'b0, 5'd26, 5'd5,  9'd160, 1'b0};
        vecs[2]  = '{9'd511, 6'd63, 8'd255, 1'b1, 5'd26, 5'd17, 9'd511, 1'b1};
        vecs[3]  = '{9'd487, 6'd0,  8'd0,   1'b1, 5'd24, 5'd3,  9'd511, 1'b0};
        vecs[4]  = '{9'd487, 6'd0,  8'd0,   1'b1, 5'd25, 5'd4,  9'd511, 1'b1};
        vecs[5]  = '{9'd0,   6'd0,  8'd0,   1'b0, 5'd0,  5'd0,  9'd0,   1'b0};
        vecs[6]  = '{9'd0,   6'd63, 8'd0,   1'b0, 5'd0,  5'd1,  9'd252, 1'b0};
        vecs[7]  = '{9'd0,   6'd0,  8'd255, 1'b0, 5'd0,  5'd2,  9'd255, 1'b0};
        vecs[8]  = '{9'd0,   6'd0,  8'd0,   1'b1, 5'd26, 5'd6,  9'd26,  1'b0};
        vecs[9]  = '{9'd200, 6'd50, 8'd100, 1'b0, 5'd0,  5'd7,  9'd500, 1'b0};
        vecs[10] = '{9'd300, 6'd30, 8'd50,  1'b1, 5'd13, 5'd8,  9'd483, 1'b0};
        vecs[11] = '{9'd511, 6'd0,  8'd0,   1'b0, 5'd0,  5'd9,  9'd511, 1'b0};
        vecs[12] = '{9'd256, 6'd63, 8'd3,   1'b0, 5'd0,  5'd10, 9'd511, 1'b0};
        vecs[13] = '{9'd256, 6'd63, 8'd4,   1'b0, 5'd0,  5'd11, 9'd511, 1'b1};
        vecs[14] = '{9'd500, 6'd0,  8'd0,   1'b0, 5'd26, 5'd12, 9'd500, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_att_out", int'(att_out), 0);
        chk("rst_op_num_out", int'(op_num_out), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table: each vector opens its own frame so sat_flag is per vector
        for (int i = 0; i < 15; i++) begin
            send(vecs[i], 1'b1, lat);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_att", i), int'(att_out), int'(vecs[i].att));
            chk($sformatf("v%0d_op", i), int'(op_num_out), int'(vecs[i].op));
            chk($sformatf("v%0d_sat", i), int'(sat_flag), int'(vecs[i].sat));
            tick();
            chk($sformatf("v%0d_idle_valid", i), int'(out_valid), 0);
            chk($sformatf("v%0d_idle_hold", i), int'(att_out), int'(vecs[i].att));
        end

        // Sticky flag survives a clean sample, clears on the next frame strobe
        send(vecs[2], 1'b1, lat);
        chk("sticky_set", int'(sat_flag), 1);
        send(vecs[0], 1'b0, lat);
        chk("sticky_att", int'(att_out), 186);
        chk("sticky_hold", int'(sat_flag), 1);
        pulse_sce();
        chk("sticky_clear", int'(sat_flag), 0);

        // Saturation in the same cycle as the strobe: set wins
        @(negedge clk);
        v = vecs[4];
        env_in = v.env; tl = v.tl; ksl_att = v.ksl;
        am_en = v.am_en; am_val = v.am; op_num = v.op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        chk("setwins_valid", int'(out_valid), 1);
        chk("setwins_sat", int'(sat_flag), 1);
        pulse_sce();
        chk("setwins_clear", int'(sat_flag), 0);

        // AM frame hold: depth changes mid-frame before slot 17
        @(negedge clk);
        am_val = 5'd10;
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        repeat (2) tick();
        v = '{9'd0, 6'd0, 8'd0, 1'b1, 5'd20, 5'd17, 9'd0, 1'b0};
        send(v, 1'b0, lat);
        chk("hold_latency", lat, 3);
`ifdef AM_FRAME_HOLD_EN
        chk("hold_att", int'(att_out), 10);
`else
        chk("hold_att", int'(att_out), 20);
`endif
        chk("hold_op", int'(op_num_out), 17);

        // 18 back-to-back operators, reset on the second drain cycle
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k <= 18) begin
                in_valid = 1'b1;
                op_num   = 5'(k - 1);
                env_in   = 9'((k - 1) * 20);
                tl       = '0;
                ksl_att  = '0;
                am_en    = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k >= 3) begin
                chk($sformatf("b2b%0d_valid", k), int'(out_valid), 1);
                chk($sformatf("b2b%0d_att", k), int'(att_out), (k - 3) * 20);
                chk($sformatf("b2b%0d_op", k), int'(op_num_out), k - 3);
            end else begin
                chk($sformatf("b2b%0d_valid", k), int'(out_valid), 0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_att", int'(att_out), 0);
        chk("midrst_op", int'(op_num_out), 0);
        chk("midrst_sat", int'(sat_flag), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("drain%0d_valid", k), int'(out_valid), 0);
            chk($sformatf("drain%0d_att", k), int'(att_out), 0);
        end
        send(vecs[0], 1'b1, lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_att", int'(att_out), 186);
        chk("post_rst_op", int'(op_num_out), 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
